// File: rtl/eflags_if.sv
// Decode/writeback/reader bundle for the EFLAGS controller.
// The pipeline side drives the requests as master; eflags_ctrl is the slave.
interface eflags_if;
  logic        flush;
  logic        rsv_valid;
  logic [6:0]  rsv_mask;
  logic        rsv_ready;
  logic        wa_valid;
  logic [6:0]  wa_mask;
  logic [31:0] wa_flags;
  logic        wa_ready;
  logic        wb_valid;
  logic [6:0]  wb_mask;
  logic [31:0] wb_flags;
  logic        wb_ready;
  logic [6:0]  rd_mask;
  logic        rd_stall;
  logic [31:0] flags;
  logic        sb_err;

  modport master (
    output flush, rsv_valid, rsv_mask, wa_valid, wa_mask, wa_flags,
           wb_valid, wb_mask, wb_flags, rd_mask,
    input  rsv_ready, wa_ready, wb_ready, rd_stall, flags, sb_err
  );

  modport slave (
    input  flush, rsv_valid, rsv_mask, wa_valid, wa_mask, wa_flags,
           wb_valid, wb_mask, wb_flags, rd_mask,
    output rsv_ready, wa_ready, wb_ready, rd_stall, flags, sb_err
  );
endinterface

// File: rtl/eflags_ctrl.sv
// Architectural EFLAGS register with per-flag in-flight scoreboard and two arbitrated writers.
// Optional macro EFLAGS_BYPASS_EN forwards this cycle's writes to flags and rd_stall.
module eflags_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  eflags_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [31:0]      FLAG_MASK = 32'h0000_0CD5;

  // Spread a 7-bit {OF,DF,SF,ZF,AF,PF,CF} select onto register bit positions.
  function automatic logic [31:0] mask_to_bits(input logic [6:0] m);
    logic [31:0] b;
    b     = 32'h0000_0000;
    b[0]  = m[0];
    b[2]  = m[1];
    b[4]  = m[2];
    b[6]  = m[3];
    b[7]  = m[4];
    b[10] = m[5];
    b[11] = m[6];
    return b;
  endfunction

  logic [CNT_W-1:0] cnt_r [7];
  logic [31:0]      flags_r;
  logic             sb_err_r;

  logic             rsv_sat_s;
  logic             rsv_acc_s;
  logic             overlap_s;
  logic             wb_acc_s;
  logic [6:0]       dec_a_s;
  logic [6:0]       dec_b_s;
  logic [6:0]       dec_s;
  logic [6:0]       inc_s;
  logic [6:0]       pend_s;
  logic [31:0]      sel_a_s;
  logic [31:0]      sel_b_s;
  logic [31:0]      flags_nxt_s;
  logic             err_s;

  // Arbitration, counter steering, next flag value and pending view.
  always_comb begin
    rsv_sat_s = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rsv_sat_s = rsv_sat_s | (bus.rsv_mask[i] & (cnt_r[i] == CNT_MAX));
    end
    overlap_s   = bus.wa_valid & (|(bus.wa_mask & bus.wb_mask));
    wb_acc_s    = bus.wb_valid & ~overlap_s;
    rsv_acc_s   = bus.rsv_valid & ~rsv_sat_s & ~bus.flush;
    dec_a_s     = {7{bus.wa_valid}} & bus.wa_mask;
    dec_b_s     = {7{wb_acc_s}} & bus.wb_mask;
    dec_s       = dec_a_s | dec_b_s;
    inc_s       = {7{rsv_acc_s}} & bus.rsv_mask;
    sel_a_s     = mask_to_bits(dec_a_s);
    sel_b_s     = mask_to_bits(dec_b_s);
    flags_nxt_s = ((flags_r & ~(sel_a_s | sel_b_s))
                  | (bus.wa_flags & sel_a_s)
                  | (bus.wb_flags & sel_b_s)) & FLAG_MASK;
    err_s       = 1'b0;
    pend_s      = 7'b000_0000;
    for (int i = 0; i < 7; i++) begin
      err_s = err_s | (dec_s[i] & ~inc_s[i] & (cnt_r[i] == CNT_ZERO));
`ifdef EFLAGS_BYPASS_EN
      // A decrement landing this cycle releases the reader immediately.
      pend_s[i] = dec_s[i] ? (cnt_r[i] > CNT_W'(1)) : (cnt_r[i] != CNT_ZERO);
`else
      pend_s[i] = (cnt_r[i] != CNT_ZERO);
`endif
    end
    err_s = err_s & ~bus.flush;
  end

  // Per-flag pending counters; flush wins over any same-cycle inc/dec.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) cnt_r[i] <= CNT_ZERO;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (bus.flush) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (inc_s[i] && !dec_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else if (dec_s[i] && !inc_s[i] && (cnt_r[i] != CNT_ZERO)) begin
          cnt_r[i] <= cnt_r[i] - CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Architectural flags and sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r  <= 32'h0000_0000;
      sb_err_r <= 1'b0;
    end else begin
      flags_r  <= flags_nxt_s;
      sb_err_r <= sb_err_r | err_s;
    end
  end

  assign bus.rsv_ready = ~rsv_sat_s;
  assign bus.wa_ready  = 1'b1;
  assign bus.wb_ready  = ~rst_n | ~overlap_s;
  assign bus.rd_stall  = |(bus.rd_mask & pend_s);
  assign bus.sb_err    = sb_err_r;
`ifdef EFLAGS_BYPASS_EN
  assign bus.flags     = rst_n ? flags_nxt_s : 32'h0000_0000;
`else
  assign bus.flags     = flags_r;
`endif

endmodule

// File: tb/tb_eflags_ctrl.sv
// Directed bench for eflags_ctrl: per-flag behavioural model checked every cycle
// plus hand-computed expectations at the key points of each scenario.
module tb_eflags_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eflags_if bus();
  eflags_ctrl #(.CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  // Model state: one pending count and one value per architectural flag.
  int cnt_m [7];
  bit fv_m [7];
  bit err_m;
  int pos [7] = '{0, 2, 4, 6, 7, 10, 11};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit m_rsv_ready();
    for (int i = 0; i < 7; i++)
      if (bus.rsv_mask[i] && cnt_m[i] == 7) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_wb_acc();
    return bus.wb_valid && !(bus.wa_valid && ((bus.wa_mask & bus.wb_mask) != 7'h00));
  endfunction

  function automatic bit m_a_hit(int i);
    return bus.wa_valid && bus.wa_mask[i];
  endfunction

  function automatic bit m_b_hit(int i);
    return m_wb_acc() && bus.wb_mask[i];
  endfunction

  function automatic logic [31:0] m_flags();
    logic [31:0] f;
    bit v;
    f = 32'h0;
    if (!rst_n) return f;
    for (int i = 0; i < 7; i++) begin
      v = fv_m[i];
`ifdef EFLAGS_BYPASS_EN
      if (m_a_hit(i)) v = bus.wa_flags[pos[i]];
      else if (m_b_hit(i)) v = bus.wb_flags[pos[i]];
`endif
      f[pos[i]] = v;
    end
    return f;
  endfunction

  function automatic bit m_stall();
    int p;
    for (int i = 0; i < 7; i++) begin
      p = cnt_m[i];
`ifdef EFLAGS_BYPASS_EN
      if (m_a_hit(i) || m_b_hit(i)) p = (p > 0) ? p - 1 : 0;
`endif
      if (bus.rd_mask[i] && p > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Model update on each clock edge (async reset clears everything).
  always @(posedge clk or negedge rst_n) begin
    bit rr;
    bit a;
    bit b;
    bit inc;
    int n;
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) begin cnt_m[i] = 0; fv_m[i] = 1'b0; end
      err_m = 1'b0;
    end else begin
      rr = m_rsv_ready();
      for (int i = 0; i < 7; i++) begin
        a = m_a_hit(i);
        b = m_b_hit(i);
        inc = bus.rsv_valid && rr && !bus.flush && bus.rsv_mask[i];
        if (a) fv_m[i] = bus.wa_flags[pos[i]];
        else if (b) fv_m[i] = bus.wb_flags[pos[i]];
        if (bus.flush) begin
          cnt_m[i] = 0;
        end else begin
          n = cnt_m[i] + (inc ? 1 : 0) - ((a || b) ? 1 : 0);
          if (n < 0) begin n = 0; err_m = 1'b1; end
          cnt_m[i] = n;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("rsv_ready", bus.rsv_ready, m_rsv_ready());
      chk("wa_ready", bus.wa_ready, 1'b1);
      chk("wb_ready", bus.wb_ready, !rst_n || !(bus.wa_valid && ((bus.wa_mask & bus.wb_mask) != 7'h00)));
      chk("rd_stall", bus.rd_stall, m_stall());
      chk("flags", bus.flags, m_flags());
      chk("sb_err", bus.sb_err, err_m);
    end
  end

  task automatic idle();
    bus.flush = 1'b0;
    bus.rsv_valid = 1'b0; bus.rsv_mask = 7'h00;
    bus.wa_valid = 1'b0; bus.wa_mask = 7'h00; bus.wa_flags = 32'h0;
    bus.wb_valid = 1'b0; bus.wb_mask = 7'h00; bus.wb_flags = 32'h0;
    bus.rd_mask = 7'h00;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    started = 1'b1;
    // Reset with conflicting writers present.
    repeat (2) @(posedge clk);
    #1;
    bus.wa_valid = 1'b1; bus.wa_mask = 7'h08; bus.wb_valid = 1'b1; bus.wb_mask = 7'h08;
    bus.rd_mask = 7'h7F;
    #1;
    chk("reset_wb_ready", bus.wb_ready, 1'b1);
    chk("reset_rsv_ready", bus.rsv_ready, 1'b1);
    chk("reset_rd_stall", bus.rd_stall, 1'b0);
    chk("reset_flags", bus.flags, 32'h0);
    chk("reset_sb_err", bus.sb_err, 1'b0);
    cyc();
    idle();
    rst_n = 1'b1;

    // Reserve ZF|CF, reader waits on ZF, writeback clears it.
    cyc();
    bus.rsv_valid = 1'b1; bus.rsv_mask = 7'h09; bus.rd_mask = 7'h08;
    #1 chk("rsv_ready_idle", bus.rsv_ready, 1'b1);
    chk("rd_stall_before", bus.rd_stall, 1'b0);
    cyc();
    bus.rsv_valid = 1'b0;
    #1 chk("rd_stall_pending", bus.rd_stall, 1'b1);
    bus.wa_valid = 1'b1; bus.wa_mask = 7'h09; bus.wa_flags = 32'h41;
    #1;
`ifdef EFLAGS_BYPASS_EN
    chk("bypass_flags_41", bus.flags, 32'h41);
    chk("bypass_rd_stall", bus.rd_stall, 1'b0);
`else
    chk("flags_not_yet", bus.flags, 32'h0);
    chk("rd_stall_wb_cycle", bus.rd_stall, 1'b1);
`endif
    cyc();
    bus.wa_valid = 1'b0;
    #1 chk("flags_41", bus.flags, 32'h41);
    chk("rd_stall_released", bus.rd_stall, 1'b0);

    // Saturate CF counter.
    bus.rsv_valid = 1'b1; bus.rsv_mask = 7'h01;
    repeat (7) cyc();
    chk("rsv_ready_sat", bus.rsv_ready, 1'b0);
    bus.rsv_valid = 1'b0; bus.rsv_mask = 7'h02;
    #1 chk("rsv_ready_other", bus.rsv_ready, 1'b1);
    bus.rsv_mask = 7'h01;
    bus.wa_valid = 1'b1; bus.wa_mask = 7'h01; bus.wa_flags = 32'h0;
    cyc();
    bus.wa_valid = 1'b0; bus.rd_mask = 7'h01;
    #1 chk("rsv_ready_after_dec", bus.rsv_ready, 1'b1);
    chk("rd_stall_cf6", bus.rd_stall, 1'b1);
    bus.wa_valid = 1'b1;
    repeat (6) cyc();
    bus.wa_valid = 1'b0;
    #1 chk("rd_stall_cf_drained", bus.rd_stall, 1'b0);
    chk("flags_40", bus.flags, 32'h40);

    // Overlapping A/B: B stalls, then retries alone.
    bus.rsv_valid = 1'b1; bus.rsv_mask = 7'h28;
    cyc();
    bus.rsv_mask = 7'h08;
    cyc();
    bus.rsv_valid = 1'b0;
    bus.wa_valid = 1'b1; bus.wa_mask = 7'h08; bus.wa_flags = 32'h0;
    bus.wb_valid = 1'b1; bus.wb_mask = 7'h28; bus.wb_flags = 32'h440;
    #1 chk("wb_ready_overlap", bus.wb_ready, 1'b0);
    cyc();
    bus.wa_valid = 1'b0;
    #1 chk("wb_ready_retry", bus.wb_ready, 1'b1);
`ifdef EFLAGS_BYPASS_EN
    chk("bypass_flags_440", bus.flags, 32'h440);
`else
    chk("flags_after_a", bus.flags, 32'h0);
`endif
    cyc();
    bus.wb_valid = 1'b0;
    #1 chk("flags_440", bus.flags, 32'h440);

    // Non-overlapping A/B commit together.
    bus.rsv_valid = 1'b1; bus.rsv_mask = 7'h21;
    cyc();
    bus.rsv_valid = 1'b0;
    bus.wa_valid = 1'b1; bus.wa_mask = 7'h01; bus.wa_flags = 32'h1;
    bus.wb_valid = 1'b1; bus.wb_mask = 7'h20; bus.wb_flags = 32'h0;
    #1 chk("wb_ready_disjoint", bus.wb_ready, 1'b1);
    chk("wa_ready_disjoint", bus.wa_ready, 1'b1);
    cyc();
    bus.wa_valid = 1'b0; bus.wb_valid = 1'b0;
    #1 chk("flags_41_pair", bus.flags, 32'h41);
    chk("sb_err_clean", bus.sb_err, 1'b0);

    // Flush with a same-cycle write and a dropped reserve.
    bus.rsv_valid = 1'b1; bus.rsv_mask = 7'h40;
    repeat (2) cyc();
    bus.rsv_valid = 1'b0; bus.rd_mask = 7'h40;
    #1 chk("rd_stall_of", bus.rd_stall, 1'b1);
    bus.flush = 1'b1;
    bus.wa_valid = 1'b1; bus.wa_mask = 7'h40; bus.wa_flags = 32'h800;
    bus.rsv_valid = 1'b1; bus.rsv_mask = 7'h01;
    cyc();
    bus.flush = 1'b0; bus.wa_valid = 1'b0; bus.rsv_valid = 1'b0; bus.rd_mask = 7'h7F;
    #1 chk("flush_flags", bus.flags, 32'h841);
    chk("flush_sb_err", bus.sb_err, 1'b0);
    chk("flush_rd_stall", bus.rd_stall, 1'b0);
    bus.wa_valid = 1'b1; bus.wa_mask = 7'h40; bus.wa_flags = 32'h0;
    cyc();
    bus.wa_valid = 1'b0;
    #1 chk("underflow_sb_err", bus.sb_err, 1'b1);
    chk("underflow_flags", bus.flags, 32'h41);
    repeat (2) cyc();
    chk("sb_err_sticky", bus.sb_err, 1'b1);

    // Reserved bits never take write data.
    bus.wa_valid = 1'b1; bus.wa_mask = 7'h7F; bus.wa_flags = 32'hFFFF_FFFF;
    #1;
`ifdef EFLAGS_BYPASS_EN
    chk("bypass_flags_cd5", bus.flags, 32'h0000_0CD5);
`endif
    cyc();
    bus.wa_valid = 1'b0;
    #1 chk("flags_cd5", bus.flags, 32'h0000_0CD5);

    // Asynchronous reset mid-operation.
    bus.rsv_valid = 1'b1; bus.rsv_mask = 7'h7F;
    cyc();
    bus.rsv_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("async_flags", bus.flags, 32'h0);
    chk("async_sb_err", bus.sb_err, 1'b0);
    chk("async_rd_stall", bus.rd_stall, 1'b0);
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("post_reset_rd_stall", bus.rd_stall, 1'b0);

    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/eflags_ctrl.md
Name: eflags_ctrl

Overview:
- Owns the architectural EFLAGS register and a per-flag in-flight scoreboard for the pipeline.
- Decode reserves the flags an instruction will write. Two writers update the flags under arbitration:
  - Port A: execute writeback.
  - Port B: POPF/CLD/STD micro-ops.
- Readers get the current flags, plus a stall whenever a flag they need is still pending.
- Register layout: OF=11, DF=10, SF=7, ZF=6, AF=4, PF=2, CF=0; all other bits read 0.

Parameters:
- CNT_W, 3, width of each per-flag pending counter (saturates at 2^CNT_W-1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; clears all pending counters.
- rsv_valid  in  1  decode reserve request.
- rsv_mask  in  7  flags to reserve, order {OF,DF,SF,ZF,AF,PF,CF}.
- rsv_ready  out  1  reserve accepted this cycle.
- wa_valid  in  1  port A write request.
- wa_mask  in  7  port A flag select, same order.
- wa_flags  in  32  port A new values, in register layout.
- wa_ready  out  1  port A accepted.
- wb_valid  in  1  port B write request.
- wb_mask  in  7  port B flag select.
- wb_flags  in  32  port B new values.
- wb_ready  out  1  port B accepted.
- rd_mask  in  7  flags needed by the current reader.
- rd_stall  out  1  one or more requested flags are pending.
- flags  out  32  architectural EFLAGS.
- sb_err  out  1  sticky scoreboard underflow error.

Behaviour:
- Reset (rst_n low, async):
  - flags=32'h0, all counters=0, sb_err=0.
  - Outputs during reset: rsv_ready=1, wa_ready=1, wb_ready=1, rd_stall=0.
- Reserve:
  - rsv_ready=0 if any counter selected by rsv_mask is saturated, else 1.
  - Accept = rsv_valid & rsv_ready & ~flush. Each selected counter increments at the next edge.
  - rsv_mask=0 is accepted with no effect.
- Port A:
  - wa_ready is always 1.
  - On wa_valid, each masked flag bit loads from wa_flags at the next edge, and each masked counter decrements.
- Port B:
  - wb_ready=0 when wa_valid=1 and (wa_mask & wb_mask)!=0; port A has priority.
  - Otherwise wb_ready=1. An accepted write updates masked bits and decrements masked counters.
  - Non-overlapping A and B writes commit in the same cycle.
- Counter arithmetic, per flag, per cycle:
  - next = cnt + inc − dec, where inc∈{0,1} and dec∈{0,1}.
  - Only one of A/B can decrement a given flag in a cycle, because overlap stalls B.
  - Increment and decrement together leave the counter unchanged.
  - A decrement of a 0 counter with no increment leaves it at 0 and sets sb_err (sticky until reset).
- Flush:
  - All counters go to 0 at the next edge, overriding any same-cycle inc/dec. No sb_err is raised from that cycle.
  - Writes accepted in the flush cycle still update flags.
  - rsv_ready is unaffected by flush; a reserve in the flush cycle is dropped.
- Reads:
  - rd_stall = OR over flags of (rd_mask[i] & cnt[i]!=0), using current-state counters.
  - flags is registered; a write is visible one cycle after acceptance.
- Reserved bits 31:12, 9:8, 5, 3, 1 are always 0 regardless of write data.
- rst_n asserted mid-operation discards all pending state immediately.

Optional Feature:
- Macro EFLAGS_BYPASS_EN.
- When defined:
  - flags is forwarded combinationally: register value with this cycle's accepted A/B masked bits merged in.
  - rd_stall is computed from post-decrement counter values (cnt − dec, ignoring this cycle's increment). A reader can therefore proceed in the writeback cycle.
- When undefined: registered flags and current-state rd_stall, as described above.

Test Plan:
- Reset, then rsv ZF|CF (7'b0001001), then rd_mask=ZF → rd_stall=1 next cycle. Then wa_valid with mask ZF|CF, wa_flags=32'h41 → flags=32'h41 and rd_stall=0 one cycle later.
- CNT_W=3, reserve CF 7 times → rsv_ready=0 when rsv_mask includes CF. A port-A CF write → counter 6 and rsv_ready=1.
- Same cycle: wa mask=ZF, wb mask=ZF|DF → wb_ready=0. Next cycle wb retried alone → wb_ready=1, DF/ZF take wb_flags values.
- Same cycle: wa mask=CF, wb mask=DF (non-overlap) → both ready; flags shows bit0 and bit10 updated together next cycle.
- Reserve OF twice, then flush plus a wa write of OF=1 in the same cycle → all counters 0, flags[11]=1, sb_err=0. Then a wa write of OF with counter 0 → sb_err=1, stays set.
- wa_flags=32'hFFFFFFFF, mask=7'h7F → flags=32'h00000CD5. With EFLAGS_BYPASS_EN, flags shows 32'h00000CD5 in the write cycle itself.
